// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl : load-use stall, branch flush and EX-operand forwarding
// control with a shadow EX/MEM/WB tag pipeline.            Rev 1.0
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int Nbits        = 64,
  parameter int AW           = 5,
  parameter int LOAD_LAT     = 1,
  parameter int BR_FLUSH     = 2,
  parameter bit X0_HARDWIRED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             br_taken,
  output logic             stall,
  output logic [2:0]       flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [Nbits-1:0] cyc_cnt,
  output logic [Nbits-1:0] stall_cnt,
  output logic [Nbits-1:0] flush_cnt
);
  localparam logic [1:0]       SCNT_LOAD = 2'(LOAD_LAT - 1);
  localparam logic [Nbits-1:0] CNT_ONE   = Nbits'(1);

  // MEM and WB only keep the fields that later checks actually look at.
  logic          ex_valid, ex_rw, ex_mr, ex_use1, ex_use2;
  logic [AW-1:0] ex_rd, ex_rs1, ex_rs2;
  logic          mem_valid, mem_rw, mem_mr;
  logic [AW-1:0] mem_rd;
  logic          wb_valid, wb_rw;
  logic [AW-1:0] wb_rd;
  logic [1:0]    scnt;
  logic          hazard;

  function automatic logic hit(input logic v, input logic rw, input logic [AW-1:0] rd,
                               input logic [AW-1:0] r, input logic use_bit);
    hit = v & rw & use_bit & (rd == r) & ~(X0_HARDWIRED & (rd == '0));
  endfunction

  assign hazard = id_valid & ex_mr &
                  (hit(ex_valid, ex_rw, ex_rd, id_rs1, id_use_rs1) |
                   hit(ex_valid, ex_rw, ex_rd, id_rs2, id_use_rs2));

  // A taken branch makes the stalled ID instruction wrong-path, so it wins.
  assign stall = ~br_taken & (hazard | (scnt != 2'd0));

  for (genvar i = 0; i < 3; i++) begin : g_flush
    assign flush[i] = (i < BR_FLUSH) ? br_taken : 1'b0;
  end

  // A load sitting in MEM never forwards from MEM; its data only exists at WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_valid) begin
      if (hit(mem_valid & ~mem_mr, mem_rw, mem_rd, ex_rs1, ex_use1)) fwd_a = 2'b10;
      else if (hit(wb_valid, wb_rw, wb_rd, ex_rs1, ex_use1))       fwd_a = 2'b01;
      if (hit(mem_valid & ~mem_mr, mem_rw, mem_rd, ex_rs2, ex_use2)) fwd_b = 2'b10;
      else if (hit(wb_valid, wb_rw, wb_rd, ex_rs2, ex_use2))       fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
      scnt      <= 2'd0;
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_valid  <= mem_valid;
      wb_rw     <= mem_rw;
      wb_rd     <= mem_rd;

      mem_valid <= ex_valid & ~flush[2];
      mem_rw    <= ex_rw;
      mem_mr    <= ex_mr;
      mem_rd    <= ex_rd;

      ex_valid  <= id_valid & ~stall & ~flush[1];
      ex_rw     <= id_reg_write;
      ex_mr     <= id_mem_read;
      ex_rd     <= id_rd;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_use1   <= id_use_rs1;
      ex_use2   <= id_use_rs2;

      if (br_taken)                    scnt <= 2'd0;
      else if (hazard && scnt == 2'd0) scnt <= SCNT_LOAD;
      else if (scnt != 2'd0)           scnt <= scnt - 2'd1;

      if (cyc_cnt != '1)               cyc_cnt   <= cyc_cnt + CNT_ONE;
      if (stall && stall_cnt != '1)    stall_cnt <= stall_cnt + CNT_ONE;
      if (br_taken && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
endmodule
`default_nettype wire
